// File: rtl/input_conditioner.sv
// Push-button conditioner: 2-flop synchronizers, per-button debounce with press pulses,
// left/right lockout and a gravity tick timer. Define AUTOREPEAT_EN to add left/right auto-repeat.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned GRAVITY_CYCLES  = 25000000,
    parameter int unsigned REPEAT_DELAY    = 15000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic btn_left_n,
    input  logic btn_right_n,
    input  logic btn_rot_n,
    input  logic gravity_en,
    output logic left_final,
    output logic right_final,
    output logic rot_final,
    output logic tick_gravity
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned GR_W = $clog2(GRAVITY_CYCLES) + 1;
    localparam logic [GR_W-1:0] GR_LAST = GR_W'(GRAVITY_CYCLES - 1);

    // Every period parameter must be at least one cycle.
    if (DEBOUNCE_CYCLES == 0 || GRAVITY_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_RATE == 0)
    begin : g_bad_cfg
        $error("input_conditioner: all cycle parameters must be non-zero");
    end

    // Button index: 0 = left, 1 = right, 2 = rotate.
    logic [2:0]      w_btn_raw_n;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_stable;
    logic [DB_W-1:0] r_db_cnt [3];
    logic [2:0]      w_db_hit;
    logic [2:0]      w_press;

    logic            w_left_evt;
    logic            w_right_evt;

    logic            r_left_final;
    logic            r_right_final;
    logic            r_rot_final;

    logic [GR_W-1:0] r_grav_cnt;
    logic            r_tick_gravity;

    assign w_btn_raw_n = {btn_rot_n, btn_right_n, btn_left_n};

    always_comb begin
        w_db_hit = '0;
        w_press  = '0;
        for (int i = 0; i < 3; i++) begin
            w_db_hit[i] = (r_sync2[i] != r_stable[i]) && (r_db_cnt[i] == DB_LAST);
            w_press[i]  = w_db_hit[i] & r_sync2[i];
        end
    end

    // Synchronizers hold the inverted (active-high) level so reset means "released".
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= ~w_btn_raw_n;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_stable[i] <= r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W = $clog2(REP_MAX) + 1;
    localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] r_rep_cnt [2];
    logic [1:0]       r_rep_phase;
    logic [1:0]       w_release;
    logic [1:0]       w_rep_fire;

    // Phase 0 waits REPEAT_DELAY after the press pulse, phase 1 repeats every REPEAT_RATE.
    always_comb begin
        w_release  = '0;
        w_rep_fire = '0;
        for (int i = 0; i < 2; i++) begin
            w_release[i]  = w_db_hit[i] & ~r_sync2[i];
            w_rep_fire[i] = r_stable[i] & ~w_release[i] &
                            (r_rep_cnt[i] == (r_rep_phase[i] ? REP_RATE_LAST : REP_DELAY_LAST));
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_rep_phase <= '0;
            for (int i = 0; i < 2; i++) begin
                r_rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!r_stable[i] || w_release[i]) begin
                    r_rep_cnt[i]   <= '0;
                    r_rep_phase[i] <= 1'b0;
                end else if (w_rep_fire[i]) begin
                    r_rep_cnt[i]   <= '0;
                    r_rep_phase[i] <= 1'b1;
                end else begin
                    r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_left_evt  = w_press[0] | w_rep_fire[0];
    assign w_right_evt = w_press[1] | w_rep_fire[1];
`else
    assign w_left_evt  = w_press[0];
    assign w_right_evt = w_press[1];
`endif

    // Simultaneous left and right events cancel each other.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_left_final  <= 1'b0;
            r_right_final <= 1'b0;
            r_rot_final   <= 1'b0;
        end else begin
            r_left_final  <= w_left_evt & ~w_right_evt;
            r_right_final <= w_right_evt & ~w_left_evt;
            r_rot_final   <= w_press[2];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_grav_cnt     <= '0;
            r_tick_gravity <= 1'b0;
        end else if (!gravity_en) begin
            r_grav_cnt     <= '0;
            r_tick_gravity <= 1'b0;
        end else if (r_grav_cnt == GR_LAST) begin
            r_grav_cnt     <= '0;
            r_tick_gravity <= 1'b1;
        end else begin
            r_grav_cnt     <= r_grav_cnt + 1'b1;
            r_tick_gravity <= 1'b0;
        end
    end

    assign left_final   = r_left_final;
    assign right_final  = r_right_final;
    assign rot_final    = r_rot_final;
    assign tick_gravity = r_tick_gravity;

endmodule
